axonerve_wordcount_control_s_axi: RTL and testbench
===================================================

# axonerve_wordcount_control_s_axi

AXI4-Lite slave register file driving the word-count kernel's control inputs (`ap_start`, `data_num`, `command`, `axi00_ptr0`) and collecting its status (`ap_done`, `ap_idle`). It sits directly upstream of `axonerve_wordcount_rtl_kernel` in the shell-facing control path. It converts host register accesses into a level `ap_start` plus stable scalar arguments, latches the single-cycle `ap_done` pulse into sticky status, and raises an interrupt.

## Interface
- `C_S_AXI_ADDR_WIDTH`, 6, byte-address width of the control bus
- `C_S_AXI_DATA_WIDTH`, 32, data width; only 32 is supported
- `ap_clk` in 1: single clock for all logic
- `ap_rst_n` in 1: reset, asynchronous and active-low
- `s_axi_control_awvalid`/`awready` in/out 1: write-address handshake
- `s_axi_control_awaddr` in `C_S_AXI_ADDR_WIDTH`: write byte address
- `s_axi_control_wvalid`/`wready` in/out 1: write-data handshake
- `s_axi_control_wdata` in 32; `s_axi_control_wstrb` in 4: write data and byte enables
- `s_axi_control_bvalid`/`bready` out/in 1; `s_axi_control_bresp` out 2: write response
- `s_axi_control_arvalid`/`arready` in/out 1; `s_axi_control_araddr` in `C_S_AXI_ADDR_WIDTH`: read address
- `s_axi_control_rvalid`/`rready` out/in 1; `s_axi_control_rdata` out 32; `s_axi_control_rresp` out 2: read data
- `interrupt` out 1: `GIE & (ISR[0] | ISR[1])`
- `ap_start` out 1: kernel start level
- `ap_done` in 1: kernel completion, one-cycle pulse
- `ap_idle` in 1: kernel idle level
- `data_num` out 32; `command` out 32; `axi00_ptr0` out 64: kernel scalar arguments

## Operation
- Register map (byte offsets, low 6 address bits decoded, bits [1:0] ignored):
  - 0x00 CTRL: bit0 `ap_start` (RW, set-only), bit1 `ap_done` (RO, clear-on-read), bit2 `ap_idle` (RO, live), bit3 `ap_ready` (RO, clear-on-read, mirrors done), bit7 `auto_restart` (RW).
  - 0x04 GIE: bit0.
  - 0x08 IER: bits [1:0].
  - 0x0C ISR: bits [1:0], toggle-on-write-1.
  - 0x10 `data_num`.
  - 0x18 `command`.
  - 0x1C `axi00_ptr0[31:0]`.
  - 0x20 `axi00_ptr0[63:32]`.
  - All other offsets read 0; writes to them are ignored.
- Argument registers honour `wstrb` per byte. CTRL, GIE, IER and ISR use `wstrb[0]` only.
- Writing 0 to CTRL bit0 has no effect. Writing 1 sets `ap_start`.
- `ap_start` clears in the cycle after an `ap_done` pulse.
  - If `auto_restart` is set, `ap_start` is low for exactly one cycle, then reasserts. This lets the kernel's rising-edge detector fire again.
- Done and ready bits set on an `ap_done` pulse. They clear on a completed CTRL read (rvalid && rready) only if the returned value had them set.
- ISR[0] sets on `ap_done` when IER[0] is set. ISR[1] sets on `ap_done` when IER[1] is set.
- ISR next-state is `(ISR ^ written bits) | set_events`. A set event wins over a simultaneous toggle.
- `bresp` and `rresp` are always 2'b00.
- Write FSM:
  - WRIDLE: `awready`=1. On awvalid, latch the address and go to WRDATA.
  - WRDATA: `wready`=1. On wvalid, perform the write and go to WRRESP.
  - WRRESP: `bvalid`=1. On bready, go to WRIDLE.
- Read FSM:
  - RDIDLE: `arready`=1. On arvalid, register `rdata` from the decoded address and go to RDDATA.
  - RDDATA: `rvalid`=1, `rdata` held stable. On rready, go to RDIDLE.
- The read and write FSMs are independent. A simultaneous read and write of CTRL are both serviced in the same cycle.

## Timing
- Reset values:
  - All FSMs idle: `awready`=1, `arready`=1, `wready`=0, `bvalid`=0, `rvalid`=0.
  - `rdata`=0, `ap_start`=0, `interrupt`=0.
  - All registers 0, so `data_num`, `command` and `axi00_ptr0` are 0.
- Reset asserted mid-transaction aborts it immediately. No response is issued after release.
- Write latency: AW accepted in cycle N, W accepted no earlier than N+1, register updated at the W-accept edge, `bvalid` from the next cycle.
- A written argument is visible on its output one cycle after the W handshake.
- A write of 1 to CTRL bit0 raises `ap_start` one cycle after the W handshake.
- Read latency: AR accepted in cycle N, `rvalid`=1 in cycle N+1.
- `ap_done` pulse in cycle N gives:
  - `ap_start` low from N+1;
  - done bit readable from N+1;
  - `interrupt` high at N+1 if enabled.
- The `ap_done` pulse is sampled every cycle; a pulse coincident with any bus activity is never lost.

## Test plan
- Reset, then read 0x00 → rdata=0x4 when `ap_idle`=1; all outputs at their reset values; `interrupt`=0.
- Write 0x10=0x100, 0x1C=0xDEAD0000, 0x20=0x1, 0x18=0x3 → `data_num`=0x100, `axi00_ptr0`=0x1_DEAD0000, `command`=3. Read-backs match.
- Write 0x1C with `wstrb`=4'b0001 and data 0xFFFFFFFF over 0xDEAD0000 → `axi00_ptr0[31:0]`=0xDEAD00FF.
- Write GIE=1, IER=1, CTRL=1, then pulse `ap_done` after 20 cycles:
  - `ap_start` falls the next cycle and `interrupt`=1.
  - First CTRL read returns bits 1 and 3 set; second read returns them clear.
  - ISR write of 1 drops `interrupt`.
- CTRL=0x81 (`auto_restart`), then pulse `ap_done` → `ap_start` low for exactly 1 cycle, then high again.
- Hold `bready`/`rready` low for 5 cycles → `bvalid`/`rvalid` and `rdata` stay stable, `awready`/`arready` stay 0, and a second AW is not accepted until the B handshake.

Source files
------------

// File: rtl/axonerve_wordcount_control_s_axi.sv
// AXI4-Lite control/status register file for the word-count kernel: start/args out, done/idle in, interrupt.
// Write path AW->W->B, one beat per phase; read path AR->R with rdata registered at AR accept.
module axonerve_wordcount_control_s_axi #(
  parameter int C_S_AXI_ADDR_WIDTH = 6,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                            ap_clk,
  input  logic                            ap_rst_n,
  input  logic                            s_axi_control_awvalid,
  output logic                            s_axi_control_awready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_awaddr,
  input  logic                            s_axi_control_wvalid,
  output logic                            s_axi_control_wready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_control_wstrb,
  output logic                            s_axi_control_bvalid,
  input  logic                            s_axi_control_bready,
  output logic [1:0]                      s_axi_control_bresp,
  input  logic                            s_axi_control_arvalid,
  output logic                            s_axi_control_arready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_control_araddr,
  output logic                            s_axi_control_rvalid,
  input  logic                            s_axi_control_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_control_rdata,
  output logic [1:0]                      s_axi_control_rresp,
  output logic                            interrupt,
  output logic                            ap_start,
  input  logic                            ap_done,
  input  logic                            ap_idle,
  output logic [31:0]                     data_num,
  output logic [31:0]                     command,
  output logic [63:0]                     axi00_ptr0
);
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [AW-3:0] W_CTRL = (AW-2)'(0);
  localparam logic [AW-3:0] W_GIE  = (AW-2)'(1);
  localparam logic [AW-3:0] W_IER  = (AW-2)'(2);
  localparam logic [AW-3:0] W_ISR  = (AW-2)'(3);
  localparam logic [AW-3:0] W_DNUM = (AW-2)'(4);
  localparam logic [AW-3:0] W_CMD  = (AW-2)'(6);
  localparam logic [AW-3:0] W_PLO  = (AW-2)'(7);
  localparam logic [AW-3:0] W_PHI  = (AW-2)'(8);

  typedef enum logic [1:0] {WRIDLE, WRDATA, WRRESP} wstate_e;
  typedef enum logic       {RDIDLE, RDDATA} rstate_e;

  wstate_e       wstate_q;
  rstate_e       rstate_q;
  logic [AW-3:0] waddr_q;
  logic [31:0]   rdata_q, rdata_mux;
  logic          rd_ctrl_q;
  logic          start_q, start_d, pend_q, pend_d, auto_q, auto_d;
  logic          done_q, done_d, ready_q, ready_d, gie_q, gie_d;
  logic [1:0]    ier_q, ier_d, isr_q, isr_d;
  logic [31:0]   dnum_q, cmd_q, plo_q, phi_q;
  logic          w_hs, r_done, wr_ctrl, wr_isr, start_set, ctrl_rd_done;
  logic          unused_addr_bits;

  assign unused_addr_bits      = ^{s_axi_control_awaddr[1:0], s_axi_control_araddr[1:0]};
  assign s_axi_control_awready = (wstate_q == WRIDLE);
  assign s_axi_control_wready  = (wstate_q == WRDATA);
  assign s_axi_control_bvalid  = (wstate_q == WRRESP);
  assign s_axi_control_arready = (rstate_q == RDIDLE);
  assign s_axi_control_rvalid  = (rstate_q == RDDATA);
  assign s_axi_control_bresp   = 2'b00;
  assign s_axi_control_rresp   = 2'b00;
  assign s_axi_control_rdata   = rdata_q;
  assign interrupt  = gie_q & (|isr_q);
  assign ap_start   = start_q;
  assign data_num   = dnum_q;
  assign command    = cmd_q;
  assign axi00_ptr0 = {phi_q, plo_q};

  assign w_hs         = s_axi_control_wvalid & s_axi_control_wready;
  assign r_done       = s_axi_control_rvalid & s_axi_control_rready;
  assign wr_ctrl      = w_hs && (waddr_q == W_CTRL) && s_axi_control_wstrb[0];
  assign wr_isr       = w_hs && (waddr_q == W_ISR) && s_axi_control_wstrb[0];
  assign start_set    = wr_ctrl && s_axi_control_wdata[0];
  assign ctrl_rd_done = r_done && rd_ctrl_q;

  function automatic logic [31:0] merge_be(input logic [31:0] old, input logic [31:0] d,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) res[i*8 +: 8] = be[i] ? d[i*8 +: 8] : old[i*8 +: 8];
    return res;
  endfunction

  always_comb begin
    rdata_mux = 32'h0;
    case (s_axi_control_araddr[AW-1:2])
      W_CTRL:  rdata_mux = {24'h0, auto_q, 3'b000, ready_q, ap_idle, done_q, start_q};
      W_GIE:   rdata_mux = {31'h0, gie_q};
      W_IER:   rdata_mux = {30'h0, ier_q};
      W_ISR:   rdata_mux = {30'h0, isr_q};
      W_DNUM:  rdata_mux = dnum_q;
      W_CMD:   rdata_mux = cmd_q;
      W_PLO:   rdata_mux = plo_q;
      W_PHI:   rdata_mux = phi_q;
      default: rdata_mux = 32'h0;
    endcase
  end

  // Done drops start for a cycle; auto-restart re-raises it so the kernel sees a fresh rising edge.
  always_comb begin
    start_d = start_q;
    pend_d  = pend_q;
    if (ap_done) begin
      start_d = 1'b0;
      pend_d  = auto_q | start_set;
    end else if (start_set || pend_q) begin
      start_d = 1'b1;
      pend_d  = 1'b0;
    end
    auto_d  = wr_ctrl ? s_axi_control_wdata[7] : auto_q;
    done_d  = ap_done | (done_q & ~(ctrl_rd_done & rdata_q[1]));
    ready_d = ap_done | (ready_q & ~(ctrl_rd_done & rdata_q[3]));
    gie_d   = (w_hs && waddr_q == W_GIE && s_axi_control_wstrb[0]) ? s_axi_control_wdata[0] : gie_q;
    ier_d   = (w_hs && waddr_q == W_IER && s_axi_control_wstrb[0]) ? s_axi_control_wdata[1:0] : ier_q;
    isr_d   = (isr_q ^ (wr_isr ? s_axi_control_wdata[1:0] : 2'b00)) | ({2{ap_done}} & ier_q);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      wstate_q <= WRIDLE;
      waddr_q  <= '0;
    end else begin
      case (wstate_q)
        WRIDLE: if (s_axi_control_awvalid) begin
          waddr_q  <= s_axi_control_awaddr[AW-1:2];
          wstate_q <= WRDATA;
        end
        WRDATA:  if (s_axi_control_wvalid) wstate_q <= WRRESP;
        WRRESP:  if (s_axi_control_bready) wstate_q <= WRIDLE;
        default: wstate_q <= WRIDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rstate_q  <= RDIDLE;
      rdata_q   <= 32'h0;
      rd_ctrl_q <= 1'b0;
    end else begin
      case (rstate_q)
        RDIDLE: if (s_axi_control_arvalid) begin
          rdata_q   <= rdata_mux;
          rd_ctrl_q <= (s_axi_control_araddr[AW-1:2] == W_CTRL);
          rstate_q  <= RDDATA;
        end
        RDDATA:  if (s_axi_control_rready) rstate_q <= RDIDLE;
        default: rstate_q <= RDIDLE;
      endcase
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      {start_q, pend_q, auto_q, done_q, ready_q, gie_q} <= '0;
      ier_q <= 2'b00;
      isr_q <= 2'b00;
      dnum_q <= 32'h0;
      cmd_q  <= 32'h0;
      plo_q  <= 32'h0;
      phi_q  <= 32'h0;
    end else begin
      start_q <= start_d;
      pend_q  <= pend_d;
      auto_q  <= auto_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      gie_q   <= gie_d;
      ier_q   <= ier_d;
      isr_q   <= isr_d;
      if (w_hs && waddr_q == W_DNUM) dnum_q <= merge_be(dnum_q, s_axi_control_wdata, s_axi_control_wstrb);
      if (w_hs && waddr_q == W_CMD)  cmd_q  <= merge_be(cmd_q, s_axi_control_wdata, s_axi_control_wstrb);
      if (w_hs && waddr_q == W_PLO)  plo_q  <= merge_be(plo_q, s_axi_control_wdata, s_axi_control_wstrb);
      if (w_hs && waddr_q == W_PHI)  phi_q  <= merge_be(phi_q, s_axi_control_wdata, s_axi_control_wstrb);
    end
  end
endmodule

// File: tb/tb_axonerve_wordcount_control_s_axi.sv
// Bench for the word-count control register file: read data checked through an expected-value queue.
module tb_axonerve_wordcount_control_s_axi;
  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [5:0]  awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        interrupt, ap_start, ap_done, ap_idle;
  logic [31:0] data_num, command;
  logic [63:0] axi00_ptr0;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];

  always #5 ap_clk = ~ap_clk;

  axonerve_wordcount_control_s_axi dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_axi_control_awvalid(awvalid), .s_axi_control_awready(awready), .s_axi_control_awaddr(awaddr),
    .s_axi_control_wvalid(wvalid), .s_axi_control_wready(wready),
    .s_axi_control_wdata(wdata), .s_axi_control_wstrb(wstrb),
    .s_axi_control_bvalid(bvalid), .s_axi_control_bready(bready), .s_axi_control_bresp(bresp),
    .s_axi_control_arvalid(arvalid), .s_axi_control_arready(arready), .s_axi_control_araddr(araddr),
    .s_axi_control_rvalid(rvalid), .s_axi_control_rready(rready),
    .s_axi_control_rdata(rdata), .s_axi_control_rresp(rresp),
    .interrupt(interrupt), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .data_num(data_num), .command(command), .axi00_ptr0(axi00_ptr0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge ap_clk); awvalid = 1'b1; awaddr = a;
    n = 0;
    while (!awready && n < 50) begin @(negedge ap_clk); n++; end
    if (n >= 50) chk("aw_timeout", 64'd0, 64'd1);
    @(negedge ap_clk); awvalid = 1'b0; wvalid = 1'b1; wdata = d; wstrb = s;
    n = 0;
    while (!wready && n < 50) begin @(negedge ap_clk); n++; end
    if (n >= 50) chk("w_timeout", 64'd0, 64'd1);
    @(negedge ap_clk); wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge ap_clk); n++; end
    if (n >= 50) chk("b_timeout", 64'd0, 64'd1);
    chk("bresp", 64'(bresp), 64'd0);
    @(negedge ap_clk); bready = 1'b0;
  endtask

  task automatic axi_read(input string tag, input logic [5:0] a, input logic [31:0] exp);
    int n;
    logic [31:0] e;
    sb_q.push_back(exp);
    @(negedge ap_clk); arvalid = 1'b1; araddr = a;
    n = 0;
    while (!arready && n < 50) begin @(negedge ap_clk); n++; end
    if (n >= 50) chk("ar_timeout", 64'd0, 64'd1);
    @(negedge ap_clk); arvalid = 1'b0; rready = 1'b1;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge ap_clk); n++; end
    if (n >= 50) chk("r_timeout", 64'd0, 64'd1);
    e = sb_q.pop_front();
    chk(tag, 64'(rdata), 64'(e));
    chk("rresp", 64'(rresp), 64'd0);
    @(negedge ap_clk); rready = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge ap_clk); ap_done = 1'b1;
    @(negedge ap_clk); ap_done = 1'b0;
  endtask

  initial begin
    ap_rst_n = 1'b0; ap_done = 1'b0; ap_idle = 1'b1;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0; bready = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("rst_awready", 64'(awready), 64'd1);
    chk("rst_arready", 64'(arready), 64'd1);
    chk("rst_wready", 64'(wready), 64'd0);
    chk("rst_bvalid", 64'(bvalid), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", 64'(rdata), 64'd0);
    chk("rst_start", 64'(ap_start), 64'd0);
    chk("rst_irq", 64'(interrupt), 64'd0);
    chk("rst_args", {data_num, command} | axi00_ptr0, 64'd0);
    ap_rst_n = 1'b1;

    axi_read("ctrl_idle", 6'h00, 32'h4);

    axi_write(6'h10, 32'h100, 4'hF);
    axi_write(6'h1C, 32'hDEAD0000, 4'hF);
    axi_write(6'h20, 32'h1, 4'hF);
    axi_write(6'h18, 32'h3, 4'hF);
    chk("data_num", 64'(data_num), 64'h100);
    chk("ptr0", axi00_ptr0, 64'h1_DEAD0000);
    chk("command", 64'(command), 64'h3);
    axi_read("rb_dnum", 6'h10, 32'h100);
    axi_read("rb_plo", 6'h1C, 32'hDEAD0000);
    axi_read("rb_phi", 6'h20, 32'h1);
    axi_read("rb_cmd", 6'h18, 32'h3);
    axi_read("rb_hole", 6'h14, 32'h0);
    axi_write(6'h14, 32'hFFFFFFFF, 4'hF);
    axi_read("rb_hole_wr", 6'h14, 32'h0);

    axi_write(6'h1C, 32'hFFFFFFFF, 4'b0001);
    chk("ptr0_strb", axi00_ptr0, 64'h1_DEAD00FF);

    axi_write(6'h04, 32'h1, 4'hF);
    axi_write(6'h08, 32'h1, 4'hF);
    axi_write(6'h00, 32'h1, 4'hF);
    chk("start_set", 64'(ap_start), 64'd1);
    chk("irq_idle", 64'(interrupt), 64'd0);
    repeat (20) @(negedge ap_clk);
    pulse_done();
    chk("start_fall", 64'(ap_start), 64'd0);
    chk("irq_done", 64'(interrupt), 64'd1);
    axi_read("ctrl_done", 6'h00, 32'hE);
    axi_read("ctrl_cor", 6'h00, 32'h4);
    axi_read("isr", 6'h0C, 32'h1);
    axi_write(6'h0C, 32'h1, 4'hF);
    chk("irq_clr", 64'(interrupt), 64'd0);
    axi_write(6'h00, 32'h0, 4'hF);
    chk("start_wr0", 64'(ap_start), 64'd0);

    axi_write(6'h00, 32'h81, 4'hF);
    chk("auto_start", 64'(ap_start), 64'd1);
    pulse_done();
    chk("auto_low", 64'(ap_start), 64'd0);
    @(negedge ap_clk);
    chk("auto_high", 64'(ap_start), 64'd1);
    axi_read("ctrl_auto", 6'h00, 32'h8F);
    axi_read("ctrl_auto2", 6'h00, 32'h85);

    @(negedge ap_clk); awvalid = 1'b1; awaddr = 6'h10;
    @(negedge ap_clk); awaddr = 6'h18; wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    @(negedge ap_clk); wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_bvalid", 64'(bvalid), 64'd1);
      chk("bp_awready", 64'(awready), 64'd0);
      @(negedge ap_clk);
    end
    bready = 1'b1;
    @(negedge ap_clk); bready = 1'b0;
    chk("bp_dnum", 64'(data_num), 64'h55);
    chk("bp_aw2", 64'(awready), 64'd1);
    @(negedge ap_clk); awvalid = 1'b0; wvalid = 1'b1; wdata = 32'h77;
    @(negedge ap_clk); wvalid = 1'b0; bready = 1'b1;
    @(negedge ap_clk); bready = 1'b0;
    chk("bp_cmd", 64'(command), 64'h77);

    sb_q.push_back(32'h55);
    @(negedge ap_clk); arvalid = 1'b1; araddr = 6'h10;
    @(negedge ap_clk); arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rp_rvalid", 64'(rvalid), 64'd1);
      chk("rp_rdata", 64'(rdata), 64'h55);
      chk("rp_arready", 64'(arready), 64'd0);
      @(negedge ap_clk);
    end
    rready = 1'b1;
    chk("rp_pop", 64'(rdata), 64'(sb_q.pop_front()));
    @(negedge ap_clk); rready = 1'b0;
    chk("rp_done", 64'(rvalid), 64'd0);

    @(negedge ap_clk); awvalid = 1'b1; awaddr = 6'h10;
    @(negedge ap_clk); awvalid = 1'b0;
    chk("mid_wready", 64'(wready), 64'd1);
    ap_rst_n = 1'b0;
    @(negedge ap_clk);
    chk("abort_wready", 64'(wready), 64'd0);
    chk("abort_awready", 64'(awready), 64'd1);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("abort_bvalid", 64'(bvalid), 64'd0);
    chk("abort_dnum", 64'(data_num), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
